// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with synchronous load and a registered wrap flag.
// Optional build macro GRAY_CNT_SATURATE_EN makes the counter saturate at its limits instead of wrapping.
module gray_updown_counter #(
    parameter int N    = 4,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         wrap
);

    localparam logic [N-1:0] INIT_BIN  = N'(INIT);
    localparam logic [N-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [N-1:0] MAX_BIN   = {N{1'b1}};
    localparam logic [N-1:0] MIN_BIN   = '0;

    logic [N-1:0] bin_reg;
    logic [N-1:0] bin_next;
    logic [N-1:0] gray_reg;
    logic [N-1:0] gray_next;
    logic         wrap_reg;
    logic         wrap_next;
    logic [N-1:0] load_bin;
    logic         at_max;
    logic         at_min;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_load_g2b
            assign load_bin[gi] = ^load_val[N-1:gi];
        end
    endgenerate

    assign at_max = (bin_reg == MAX_BIN);
    assign at_min = (bin_reg == MIN_BIN);

    always_comb begin
        bin_next  = bin_reg;
        gray_next = gray_reg;
        wrap_next = 1'b0;
        if (load) begin
            bin_next  = load_bin;
            gray_next = load_val;
        end else if (clk_en) begin
`ifdef GRAY_CNT_SATURATE_EN
            // A blocked step holds the count and flags overflow/underflow instead.
            if (up_dn) begin
                if (at_max) begin
                    wrap_next = 1'b1;
                end else begin
                    bin_next = bin_reg + N'(1);
                end
            end else begin
                if (at_min) begin
                    wrap_next = 1'b1;
                end else begin
                    bin_next = bin_reg - N'(1);
                end
            end
`else
            if (up_dn) begin
                bin_next  = bin_reg + N'(1);
                wrap_next = at_max;
            end else begin
                bin_next  = bin_reg - N'(1);
                wrap_next = at_min;
            end
`endif
            gray_next = bin_next ^ (bin_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= INIT_BIN;
            gray_reg <= INIT_GRAY;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign gray_out = gray_reg;
    assign bin_out  = bin_reg;
    assign wrap     = wrap_reg;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: stimulus queues expected outputs, a monitor pops and compares.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       wrap;

    logic       rst3_n = 1'b0;
    logic       en3 = 1'b0;
    logic       up3 = 1'b1;
    logic       load3 = 1'b0;
    logic [3:0] load_val3 = 4'b0000;
    logic [3:0] gray3;
    logic [3:0] bin3;
    logic       wrap3;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        logic       w;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gray_updown_counter #(.N(4), .INIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray_out(gray_out), .bin_out(bin_out), .wrap(wrap)
    );

    gray_updown_counter #(.N(4), .INIT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .clk_en(en3), .up_dn(up3), .load(load3),
        .load_val(load_val3), .gray_out(gray3), .bin_out(bin3), .wrap(wrap3)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: one output presentation per clock edge that follows an issued step.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " gray"}, {4'b0, gray_out}, {4'b0, e.g});
            check({e.tag, " bin"},  {4'b0, bin_out},  {4'b0, e.b});
            check({e.tag, " wrap"}, {7'b0, wrap},     {7'b0, e.w});
            $display("txn %s: gray=%b bin=%0d wrap=%b", e.tag, gray_out, bin_out, wrap);
        end
    end

    task automatic step(input logic ld, input logic [3:0] lv, input logic en, input logic u,
                        input logic [3:0] eg, input logic [3:0] eb, input logic ew, input string tag);
        exp_t e;
        @(negedge clk);
        load     = ld;
        load_val = lv;
        clk_en   = en;
        up_dn    = u;
        e.g = eg; e.b = eb; e.w = ew; e.tag = tag;
        sb.push_back(e);
    endtask

    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        logic [3:0] b;
        repeat (2) @(posedge clk);
        #1;
        check("reset gray", {4'b0, gray_out}, 8'h00);
        check("reset bin",  {4'b0, bin_out},  8'h00);
        check("reset wrap", {7'b0, wrap},     8'h00);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef GRAY_CNT_SATURATE_EN
        for (int i = 1; i <= 16; i++) begin
            b = 4'(i);
            step(1'b0, 4'b0000, 1'b1, 1'b1, gtab[b], b, (i == 16), $sformatf("up%0d", i));
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 4'd15, 1'b1, "down_wrap");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'd0,  1'b1, "up_wrap");
        step(1'b1, 4'b0111, 1'b1, 1'b1, 4'b0111, 4'd5,  1'b0, "load_wins");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0101, 4'd6,  1'b0, "after_load");
        step(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'd0,  1'b0, "load_zero");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'd1,  1'b0, "en1");
        step(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'd1,  1'b0, "idle1");
        step(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'd1,  1'b0, "idle2");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0011, 4'd2,  1'b0, "en2");
        step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'd1,  1'b0, "alt_dn");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0011, 4'd2,  1'b0, "alt_up");
        step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'd1,  1'b0, "alt_dn2");
        step(1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000, 4'd15, 1'b0, "load_max");
        step(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'd15, 1'b0, "hold_max");
        step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b1111, 4'd10, 1'b0, "load_1111");
`else
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'd1,  1'b0, "sat_up1");
        step(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 4'd15, 1'b0, "sat_load_max");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'd15, 1'b1, "sat_over1");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'd15, 1'b1, "sat_over2");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'd15, 1'b1, "sat_over3");
        step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1001, 4'd14, 1'b0, "sat_down");
        step(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'd0,  1'b0, "sat_load_zero");
        step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'd0,  1'b1, "sat_under");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'd1,  1'b0, "sat_up2");
        step(1'b1, 4'b0111, 1'b1, 1'b1, 4'b0111, 4'd5,  1'b0, "sat_load_wins");
`endif
        @(negedge clk);
        load   = 1'b0;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", 8'(sb.size()), 8'd0);

        // INIT=3 instance: count to 9, then reset asynchronously between edges.
        @(negedge clk);
        rst3_n = 1'b1;
        en3    = 1'b1;
        repeat (6) @(negedge clk);
        en3 = 1'b0;
        check("init3 bin9 gray", {4'b0, gray3}, 8'b0000_1101);
        check("init3 bin9 bin",  {4'b0, bin3},  8'd9);
        @(posedge clk);
        #2;
        rst3_n = 1'b0;
        #1;
        check("async rst gray", {4'b0, gray3}, 8'b0000_0010);
        check("async rst bin",  {4'b0, bin3},  8'd3);
        check("async rst wrap", {7'b0, wrap3}, 8'd0);
        $display("txn async_reset: gray=%b bin=%0d wrap=%b", gray3, bin3, wrap3);
        @(negedge clk);
        rst3_n = 1'b1;
        en3    = 1'b1;
        @(negedge clk);
        en3 = 1'b0;
        check("resume gray", {4'b0, gray3}, 8'b0000_0110);
        check("resume bin",  {4'b0, bin3},  8'd4);
        $display("txn resume: gray=%b bin=%0d wrap=%b", gray3, bin3, wrap3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
